// File: rtl/fir_tap_load_ctrl.sv
// FIR coefficient load controller: fills the shadow bank of a double-banked
// tap RAM from the decoder's tap-write stream, validates the tap count and
// swaps the active bank only on a FIR-safe sync pulse.
module fir_tap_load_ctrl #(
   parameter int unsigned TAP_NUM        = 32,
   parameter int unsigned TAP_WIDTH      = 16,
   parameter int unsigned TAP_ADDR_WIDTH = 5
) (
   input  logic                      clk_sys_i,
   input  logic                      rst_n_i,
   input  logic                      fir_tap_wr_cmd_i,
   input  logic                      fir_tap_wr_vld_i,
   input  logic [31:0]               fir_tap_wr_data_i,
   input  logic                      fir_sync_i,
   input  logic                      err_clr_i,
   output logic                      tap_ram_we_o,
   output logic [TAP_ADDR_WIDTH:0]   tap_ram_waddr_o,
   output logic [TAP_WIDTH-1:0]      tap_ram_wdata_o,
   output logic                      fir_bank_sel_o,
   output logic                      tap_update_done_o,
   output logic                      tap_err_o,
   output logic                      busy_o
);

   // Counter is one bit wider than the index so it can hold TAP_NUM itself.
   localparam int unsigned CNT_W = TAP_ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] TAP_NUM_C = CNT_W'(TAP_NUM);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_TAIL,
      ST_CHECK,
      ST_WAIT_SWAP
   } state_t;

   state_t                    state_q, state_nxt;
   logic                      cmd_q;
   logic [CNT_W-1:0]          cnt_q, cnt_nxt;
   logic                      ovf_q, ovf_nxt;
   logic                      we_nxt;
   logic [TAP_ADDR_WIDTH:0]   waddr_nxt;
   logic [TAP_WIDTH-1:0]      wdata_nxt;
   logic                      bank_nxt;
   logic                      done_nxt;
   logic                      err_nxt;
   logic                      busy_nxt;
   logic                      cmd_rise_c;
   logic                      unused_data;

   // Upper data bits carry nothing for this tap width.
   assign unused_data = ^fir_tap_wr_data_i[31:TAP_WIDTH];

   assign cmd_rise_c = fir_tap_wr_cmd_i & ~cmd_q;

   // Next-state and next-output logic.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      ovf_nxt   = ovf_q;
      we_nxt    = 1'b0;
      waddr_nxt = tap_ram_waddr_o;
      wdata_nxt = tap_ram_wdata_o;
      bank_nxt  = fir_bank_sel_o;
      done_nxt  = 1'b0;
      err_nxt   = tap_err_o & ~err_clr_i;

      case (state_q)
         ST_IDLE: begin
            if (cmd_rise_c) begin
               state_nxt = ST_LOAD;
               cnt_nxt   = '0;
               ovf_nxt   = 1'b0;
            end
         end
         ST_LOAD, ST_TAIL: begin
            if (fir_tap_wr_vld_i) begin
               if (cnt_q < TAP_NUM_C) begin
                  we_nxt    = 1'b1;
                  waddr_nxt = {~fir_bank_sel_o, cnt_q[TAP_ADDR_WIDTH-1:0]};
                  wdata_nxt = fir_tap_wr_data_i[TAP_WIDTH-1:0];
                  cnt_nxt   = cnt_q + CNT_W'(1);
               end else begin
                  ovf_nxt = 1'b1;
               end
            end
            // The tail cycle catches a strobe trailing the command fall.
            if (state_q == ST_TAIL) begin
               state_nxt = ST_CHECK;
            end else if (!fir_tap_wr_cmd_i) begin
               state_nxt = ST_TAIL;
            end
         end
         ST_CHECK: begin
            if ((cnt_q == TAP_NUM_C) && !ovf_q) begin
               state_nxt = ST_WAIT_SWAP;
            end else begin
               err_nxt   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT_SWAP: begin
            // A new frame cancels the pending swap and reloads the same bank.
            if (cmd_rise_c) begin
               state_nxt = ST_LOAD;
               cnt_nxt   = '0;
               ovf_nxt   = 1'b0;
            end else if (fir_sync_i) begin
               bank_nxt  = ~fir_bank_sel_o;
               done_nxt  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q           <= ST_IDLE;
         cmd_q             <= 1'b0;
         cnt_q             <= '0;
         ovf_q             <= 1'b0;
         tap_ram_we_o      <= 1'b0;
         tap_ram_waddr_o   <= '0;
         tap_ram_wdata_o   <= '0;
         fir_bank_sel_o    <= 1'b0;
         tap_update_done_o <= 1'b0;
         tap_err_o         <= 1'b0;
         busy_o            <= 1'b0;
      end else begin
         state_q           <= state_nxt;
         cmd_q             <= fir_tap_wr_cmd_i;
         cnt_q             <= cnt_nxt;
         ovf_q             <= ovf_nxt;
         tap_ram_we_o      <= we_nxt;
         tap_ram_waddr_o   <= waddr_nxt;
         tap_ram_wdata_o   <= wdata_nxt;
         fir_bank_sel_o    <= bank_nxt;
         tap_update_done_o <= done_nxt;
         tap_err_o         <= err_nxt;
         busy_o            <= busy_nxt;
      end
   end

endmodule
